// File: rtl/router_pkg.sv
// Shared definitions for the mesh-router input port.
// Provides the output-port indices, the port count and the XY dimension-order
// route function used at enqueue time.
package router_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned P_LOCAL   = 0;
  localparam int unsigned P_NORTH   = 1;
  localparam int unsigned P_SOUTH   = 2;
  localparam int unsigned P_EAST    = 3;
  localparam int unsigned P_WEST    = 4;

  // dest_yx / local_yx are {y,x} coordinates zero-extended to 16 bits; x_bits says
  // where x ends. X is resolved first, then Y, otherwise the packet is for this node.
  function automatic logic [NUM_PORTS-1:0] xy_route(input logic [15:0]   dest_yx,
                                                    input logic [15:0]   local_yx,
                                                    input int unsigned   x_bits);
    logic [15:0]          x_mask;
    logic [15:0]          dx, dy, lx, ly;
    logic [NUM_PORTS-1:0] sel;
    x_mask = (16'(1) << x_bits) - 16'(1);
    dx     = dest_yx & x_mask;
    lx     = local_yx & x_mask;
    dy     = dest_yx >> x_bits;
    ly     = local_yx >> x_bits;
    sel    = '0;
    if (dx > lx) begin
      sel[P_EAST] = 1'b1;
    end else if (dx < lx) begin
      sel[P_WEST] = 1'b1;
    end else if (dy > ly) begin
      sel[P_NORTH] = 1'b1;
    end else if (dy < ly) begin
      sel[P_SOUTH] = 1'b1;
    end else begin
      sel[P_LOCAL] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rt_sync_fifo.sv
// Synchronous FIFO with registered storage; the head entry is read straight out
// of storage (no output flop, no bypass).
// Ports: clk_i, rst_i (sync, active-high), push_i/wdata_i write side,
//        pop_i/rdata_o read side, full_o, empty_o status.
module rt_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      // DEPTH is a power of two, so the pointer wraps naturally.
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/router_input_port.sv
// Mesh-router input port: accepts read/write request packets over valid/ready,
// routes them XY at enqueue time, queues them and presents the head packet with
// its one-hot output-port request. Illegal packets are consumed and counted.
// Ports: clk, reset (sync, active-high), localRouterAddress {y,x};
//        in_valid/in_ready + destinationAddressIn/requesterAddressIn/readIn/writeIn;
//        out_valid/out_grant + outputPortSelect/destinationAddressOut/
//        requesterAddressOut; memRead/memWrite toward node memory; drop_count.
module router_input_port
  import router_pkg::*;
#(
  parameter  int unsigned X_BITS      = 2,
  parameter  int unsigned Y_BITS      = 2,
  parameter  int unsigned OFFSET_BITS = 8,
  parameter  int unsigned REQ_BITS    = 4,
  parameter  int unsigned DEPTH       = 4,
  localparam int unsigned ADDR_W      = Y_BITS + X_BITS + OFFSET_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [X_BITS+Y_BITS-1:0] localRouterAddress,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        destinationAddressIn,
  input  logic [REQ_BITS-1:0]      requesterAddressIn,
  input  logic                     readIn,
  input  logic                     writeIn,
  output logic                     out_valid,
  output logic [NUM_PORTS-1:0]     outputPortSelect,
  input  logic                     out_grant,
  output logic [ADDR_W-1:0]        destinationAddressOut,
  output logic [REQ_BITS-1:0]      requesterAddressOut,
  output logic                     memRead,
  output logic                     memWrite,
  output logic [7:0]               drop_count
);

  localparam int unsigned EntryW = NUM_PORTS + 2 + REQ_BITS + ADDR_W;

  logic [X_BITS+Y_BITS-1:0] dest_yx;
  logic [NUM_PORTS-1:0]     route;
  logic                     legal, accept, push, drop, pop;
  logic                     full, empty;
  logic [EntryW-1:0]        wdata, rdata;
  logic [NUM_PORTS-1:0]     head_route;
  logic                     head_read, head_write;
  logic [REQ_BITS-1:0]      head_req;
  logic [ADDR_W-1:0]        head_dest;
  logic [7:0]               drop_count_q, drop_count_d;

  assign dest_yx = destinationAddressIn[ADDR_W-1 -: X_BITS+Y_BITS];

  always_comb begin
    route = xy_route(16'(dest_yx), 16'(localRouterAddress), X_BITS);
  end

  // Reset gates the handshake outputs combinationally so nothing moves in the reset cycle.
  assign in_ready  = ~full & ~reset;
  assign out_valid = ~empty & ~reset;

  assign legal  = readIn ^ writeIn;
  assign accept = in_valid & in_ready;
  assign push   = accept & legal;
  assign drop   = accept & ~legal;
  assign pop    = out_valid & out_grant;
  assign wdata  = {route, readIn, writeIn, requesterAddressIn, destinationAddressIn};

  rt_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign {head_route, head_read, head_write, head_req, head_dest} = rdata;

  always_comb begin
    outputPortSelect      = '0;
    destinationAddressOut = '0;
    requesterAddressOut   = '0;
    memRead               = 1'b0;
    memWrite              = 1'b0;
    if (out_valid) begin
      outputPortSelect      = head_route;
      destinationAddressOut = head_dest;
      requesterAddressOut   = head_req;
      memRead               = head_route[P_LOCAL] & head_read;
      memWrite              = head_route[P_LOCAL] & head_write;
    end
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_router_input_port.sv
module tb_router_input_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  local_addr;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] dest_in;
  logic [3:0]  req_in;
  logic        rd_in, wr_in;
  logic        out_valid;
  logic [4:0]  sel;
  logic        out_grant;
  logic [11:0] dest_out;
  logic [3:0]  req_out;
  logic        mem_rd, mem_wr;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  router_input_port dut (
    .clk                   (clk),
    .reset                 (reset),
    .localRouterAddress    (local_addr),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .destinationAddressIn  (dest_in),
    .requesterAddressIn    (req_in),
    .readIn                (rd_in),
    .writeIn               (wr_in),
    .out_valid             (out_valid),
    .outputPortSelect      (sel),
    .out_grant             (out_grant),
    .destinationAddressOut (dest_out),
    .requesterAddressOut   (req_out),
    .memRead               (mem_rd),
    .memWrite              (mem_wr),
    .drop_count            (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  sel;
    logic        rd;
    logic        wr;
    logic [3:0]  req;
    logic [11:0] dest;
  } pkt_t;

  pkt_t q[$];
  int   m_drops = 0;
  bit   m_started = 0;

  function automatic logic [4:0] m_route(input logic [11:0] d, input logic [3:0] l);
    int dx, dy, lx, ly;
    dy = int'(d[11:10]); dx = int'(d[9:8]);
    ly = int'(l[3:2]);   lx = int'(l[1:0]);
    if (dx > lx) return 5'b01000;
    if (dx < lx) return 5'b10000;
    if (dy > ly) return 5'b00010;
    if (dy < ly) return 5'b00100;
    return 5'b00001;
  endfunction

  function automatic bit m_in_ready();
    return !reset && (q.size() < 4);
  endfunction

  function automatic bit m_out_valid();
    return !reset && (q.size() > 0);
  endfunction

  always @(posedge clk) begin
    bit ir, ov;
    pkt_t p;
    ir = m_in_ready();
    ov = m_out_valid();
    if (reset) begin
      q.delete();
      m_drops   = 0;
      m_started = 1;
    end else if (m_started) begin
      if (ov && out_grant) void'(q.pop_front());
      if (in_valid && ir) begin
        if (rd_in != wr_in) begin
          p.sel = m_route(dest_in, local_addr);
          p.rd = rd_in; p.wr = wr_in; p.req = req_in; p.dest = dest_in;
          q.push_back(p);
        end else if (m_drops < 255) begin
          m_drops++;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_out_valid()));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      if (m_out_valid()) begin
        chk("sel", 32'(sel), 32'(q[0].sel));
        chk("dest_out", 32'(dest_out), 32'(q[0].dest));
        chk("req_out", 32'(req_out), 32'(q[0].req));
        chk("memRead", 32'(mem_rd), 32'(q[0].sel == 5'b00001 && q[0].rd));
        chk("memWrite", 32'(mem_wr), 32'(q[0].sel == 5'b00001 && q[0].wr));
      end else begin
        chk("idle_outputs", {7'(0), sel, dest_out, req_out, mem_rd, mem_wr, 2'(0)}, 32'(0));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d, input logic [3:0] r, input logic rd,
                      input logic wr);
    in_valid = 1'b1; dest_in = d; req_in = r; rd_in = rd; wr_in = wr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_grant = 1'b1;
    tick();
    out_grant = 1'b0;
  endtask

  initial begin
    reset = 1'b1; local_addr = 4'b0101; in_valid = 1'b0; dest_in = '0; req_in = '0;
    rd_in = 1'b0; wr_in = 1'b0; out_grant = 1'b0;

    // 1. reset
    tick();
    @(negedge clk);
    chk("lit_ready_in_reset", 32'(in_ready), 32'd0);
    chk("lit_valid_in_reset", 32'(out_valid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("lit_ready_after_reset", 32'(in_ready), 32'd1);
    chk("lit_drop_after_reset", 32'(drop_count), 32'd0);
    chk("lit_mem_after_reset", {mem_rd, mem_wr}, 32'd0);
    tick();

    // 2. routes
    send(12'h623, 4'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("lit_east_valid", 32'(out_valid), 32'd1);
    chk("lit_east_sel", 32'(sel), 32'b01000);
    chk("lit_east_memwr", 32'(mem_wr), 32'd0);
    tick(); pop_one();
    send(12'h412, 4'd2, 1'b1, 1'b0);
    @(negedge clk); chk("lit_west_sel", 32'(sel), 32'b10000);
    tick(); pop_one();
    send(12'h9AB, 4'd3, 1'b1, 1'b0);
    @(negedge clk); chk("lit_north_sel", 32'(sel), 32'b00010);
    tick(); pop_one();
    send(12'h1CD, 4'd4, 1'b0, 1'b1);
    @(negedge clk); chk("lit_south_sel", 32'(sel), 32'b00100);
    tick(); pop_one();

    // 3. local read held until grant
    send(12'h540, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_local_sel", 32'(sel), 32'b00001);
      chk("lit_local_memrd", 32'(mem_rd), 32'd1);
      chk("lit_local_dest", 32'(dest_out), 32'h540);
      tick();
    end
    pop_one();
    @(negedge clk); chk("lit_local_popped", 32'(out_valid), 32'd0);
    tick();

    // 4. fill, rejected push on grant cycle, drain in order
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; dest_in = 12'h623; req_in = 4'(i); rd_in = 1'b0; wr_in = 1'b1;
      tick();
    end
    req_in = 4'd7; out_grant = 1'b1;
    @(negedge clk);
    chk("lit_full_ready", 32'(in_ready), 32'd0);
    chk("lit_full_head", 32'(req_out), 32'd1);
    tick();
    in_valid = 1'b0; out_grant = 1'b0;
    @(negedge clk);
    chk("lit_after_reject_head", 32'(req_out), 32'd2);
    chk("lit_after_reject_ready", 32'(in_ready), 32'd1);
    tick();
    out_grant = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("lit_drain_order", 32'(req_out), 32'(k));
      tick();
    end
    out_grant = 1'b0;
    @(negedge clk); chk("lit_drained", 32'(out_valid), 32'd0);
    tick();

    // 5. illegal packets
    send(12'h623, 4'd1, 1'b1, 1'b1);
    send(12'h623, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_drop_two", 32'(drop_count), 32'd2);
    chk("lit_drop_noqueue", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b1; rd_in = 1'b0; wr_in = 1'b0;
    repeat (300) tick();
    in_valid = 1'b0;
    @(negedge clk); chk("lit_drop_sat", 32'(drop_count), 32'd255);
    tick();

    // 6. reset mid-operation
    send(12'h540, 4'd1, 1'b1, 1'b0);
    send(12'h623, 4'd2, 1'b0, 1'b1);
    send(12'h412, 4'd3, 1'b1, 1'b0);
    @(negedge clk); chk("lit_pre_reset_memrd", 32'(mem_rd), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_reset_valid", 32'(out_valid), 32'd0);
    chk("lit_reset_memrd", 32'(mem_rd), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("lit_post_reset_valid", 32'(out_valid), 32'd0);
    chk("lit_post_reset_drop", 32'(drop_count), 32'd0);
    tick();
    send(12'h623, 4'd9, 1'b0, 1'b1);
    @(negedge clk); chk("lit_new_head", 32'(req_out), 32'd9);
    tick(); pop_one();
    @(negedge clk); chk("lit_new_alone", 32'(out_valid), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
